// File: rtl/ddr_seq_pkg.sv
// rtl/ddr_seq_pkg.sv - shared phase encoding and edge-count constants for the DDR word sequencer
package ddr_seq_pkg;

  // Phase codes double as the o_phase output encoding.
  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_CMD     = 3'd1,
    PH_DATA    = 3'd2,
    PH_CRC     = 3'd3,
    PH_RECOVER = 3'd4
  } phase_e;

  localparam int unsigned WORD_EDGES    = 20;
  localparam int unsigned RECOVER_EDGES = 38;
  localparam int unsigned PAYLOAD_FIRST = 2;
  localparam int unsigned PAYLOAD_LAST  = 17;
  localparam int unsigned CNT_W         = 6;

endpackage

// File: rtl/ddr_edge_counter.sv
// rtl/ddr_edge_counter.sv - registered 6-bit SCL edge counter with programmable terminal count
module ddr_edge_counter
  import ddr_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;

  // Clear dominates the enable, so a wrap is never reported in a clearing cycle.
  assign wrap_o = en_i && !clr_i && (idx_q == term_i);
  assign idx_o  = idx_q;

  // Next index: clear, wrap at terminal count, or count one edge.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = wrap_o ? '0 : idx_q + 1'b1;
    end
  end

  // Index register.
  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

endmodule

// File: rtl/ddr_word_sequencer.sv
// rtl/ddr_word_sequencer.sv - HDR-DDR frame sequencer (CRC word phase present when DDR_SEQ_CRC_EN is defined)
module ddr_word_sequencer #(
  parameter  int MAX_WORDS     = 16,
  parameter  int WORD_EDGES    = 20,
  parameter  int RECOVER_EDGES = 38,
  localparam int NW_W          = $clog2(MAX_WORDS + 1),
  localparam int WIDX_W        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic              i_start,
  input  logic [NW_W-1:0]   i_num_words,
  input  logic              i_crc_en,
  input  logic              i_err_recover,
  input  logic              i_abort,
  output logic              o_busy,
  output logic [2:0]        o_phase,
  output logic [5:0]        o_bit_idx,
  output logic [WIDX_W-1:0] o_word_idx,
  output logic              o_payload_en,
  output logic              o_word_done,
  output logic              o_frame_done
);

  import ddr_seq_pkg::*;

  localparam logic [CNT_W-1:0] WORD_TERM = CNT_W'(WORD_EDGES - 1);
  localparam logic [CNT_W-1:0] REC_TERM  = CNT_W'(RECOVER_EDGES - 1);
  localparam logic [CNT_W-1:0] PL_FIRST  = CNT_W'(PAYLOAD_FIRST);
  localparam logic [CNT_W-1:0] PL_LAST   = CNT_W'(PAYLOAD_LAST);

  phase_e              state_q, state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [WIDX_W-1:0]   last_idx_q, last_idx_d;
  logic                payload_en_q, payload_en_d;
  logic                word_done_q, word_done_d;
  logic                frame_done_q, frame_done_d;
  logic [WIDX_W-1:0]   start_last_idx;
  logic                edge_ev;
  logic                cnt_en;
  logic                cnt_clr;
  logic                cnt_wrap;
  logic [CNT_W-1:0]    cnt_idx;
  logic [CNT_W-1:0]    cnt_next;
  logic                word_phase;

`ifdef DDR_SEQ_CRC_EN
  logic crc_q, crc_d;
`else
  logic unused_crc_en;
  assign unused_crc_en = i_crc_en;
`endif

  // A cycle carrying both SCL edges counts once; IDLE holds the counter at zero.
  assign edge_ev    = i_scl_pos_edge | i_scl_neg_edge;
  assign cnt_en     = edge_ev && (state_q != PH_IDLE) && !i_abort;
  assign cnt_clr    = i_abort || (state_q == PH_IDLE);
  assign cnt_next   = cnt_idx + 1'b1;
  assign word_phase = (state_q == PH_CMD) || (state_q == PH_DATA) || (state_q == PH_CRC);

  ddr_edge_counter u_edge_counter (
    .clk_i  (i_sys_clk),
    .rst_i  (i_rst),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .term_i ((state_q == PH_RECOVER) ? REC_TERM : WORD_TERM),
    .idx_o  (cnt_idx),
    .wrap_o (cnt_wrap)
  );

  // Requested word count reduced to a last-word index: 0 means one word, excess clamps to MAX_WORDS.
  always_comb begin
    start_last_idx = '0;
    if (i_num_words == '0) begin
      start_last_idx = '0;
    end else if (i_num_words > NW_W'(MAX_WORDS)) begin
      start_last_idx = WIDX_W'(MAX_WORDS - 1);
    end else begin
      start_last_idx = WIDX_W'(i_num_words - 1'b1);
    end
  end

  // Frame FSM: phase transitions on counter wrap, strobe generation, abort override.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    last_idx_d   = last_idx_q;
    payload_en_d = 1'b0;
    word_done_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef DDR_SEQ_CRC_EN
    crc_d        = crc_q;
`endif

    case (state_q)
      PH_IDLE: begin
        word_idx_d = '0;
        if (i_err_recover) begin
          state_d = PH_RECOVER;
        end else if (i_start) begin
          state_d    = PH_CMD;
          last_idx_d = start_last_idx;
`ifdef DDR_SEQ_CRC_EN
          crc_d      = i_crc_en;
`endif
        end
      end
      PH_CMD: begin
        if (cnt_wrap) begin
          state_d     = PH_DATA;
          word_idx_d  = '0;
          word_done_d = 1'b1;
        end
      end
      PH_DATA: begin
        if (cnt_wrap) begin
          word_done_d = 1'b1;
          if (word_idx_q != last_idx_q) begin
            word_idx_d = word_idx_q + 1'b1;
          end else begin
            word_idx_d = '0;
`ifdef DDR_SEQ_CRC_EN
            if (crc_q) begin
              state_d = PH_CRC;
            end else begin
              state_d      = PH_IDLE;
              frame_done_d = 1'b1;
            end
`else
            state_d      = PH_IDLE;
            frame_done_d = 1'b1;
`endif
          end
        end
      end
`ifdef DDR_SEQ_CRC_EN
      PH_CRC: begin
        if (cnt_wrap) begin
          state_d      = PH_IDLE;
          word_done_d  = 1'b1;
          frame_done_d = 1'b1;
        end
      end
`endif
      PH_RECOVER: begin
        if (cnt_wrap) begin
          state_d      = PH_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase

    // Payload strobe tracks the index the counter is about to hold.
    if (cnt_en && word_phase && !cnt_wrap && (cnt_next >= PL_FIRST) && (cnt_next <= PL_LAST)) begin
      payload_en_d = 1'b1;
    end

    // Abort beats any coincident edge and suppresses every strobe.
    if (i_abort && (state_q != PH_IDLE)) begin
      state_d      = PH_IDLE;
      word_idx_d   = '0;
      payload_en_d = 1'b0;
      word_done_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State, word index and registered strobes.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q      <= PH_IDLE;
      word_idx_q   <= '0;
      last_idx_q   <= '0;
      payload_en_q <= 1'b0;
      word_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      last_idx_q   <= last_idx_d;
      payload_en_q <= payload_en_d;
      word_done_q  <= word_done_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DDR_SEQ_CRC_EN
  // Latched CRC request for the current frame.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) crc_q <= 1'b0;
    else       crc_q <= crc_d;
  end
`endif

  assign o_busy       = (state_q != PH_IDLE);
  assign o_phase      = state_q;
  assign o_bit_idx    = cnt_idx;
  assign o_word_idx   = word_idx_q;
  assign o_payload_en = payload_en_q;
  assign o_word_done  = word_done_q;
  assign o_frame_done = frame_done_q;

endmodule
